// File: rtl/weight_mem_arbiter.sv
// Arbitrates one weight memory between inference reads and saturating reward updates.
// Read: grant + 1 data cycle. Update: grant, read-modify, write-back.
module weight_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DW     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_learn_en,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DW-1:0]     o_rd_data,
  input  logic              i_up_req,
  input  logic [ADDR_W-1:0] i_up_addr,
  input  logic [DW-1:0]     i_up_delta,
  output logic              o_up_gnt,
  output logic              o_up_done,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    UP_CALC = 2'd2,
    UP_WR   = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_last_up;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DW-1:0]       r_delta_q;
  logic [DW-1:0]       r_wdata_q;

  logic                w_rd_elig;
  logic                w_up_elig;
  logic                w_rd_win;
  logic                w_up_win;
  logic [DW+1:0]       w_sum;
  logic [DW-1:0]       w_clamped;

  // Round-robin: on a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_rd_elig = i_rst_n && (r_state == IDLE) && i_rd_req;
    w_up_elig = i_rst_n && (r_state == IDLE) && i_up_req && i_learn_en;
    w_rd_win  = w_rd_elig && (!w_up_elig || r_last_up);
    w_up_win  = w_up_elig && (!w_rd_elig || !r_last_up);
  end

  // Unsigned weight plus signed delta, two guard bits, clamped to the weight range.
  always_comb begin
    w_sum = {2'b00, i_mem_rdata} + {{2{r_delta_q[DW-1]}}, r_delta_q};
    if (w_sum[DW+1]) begin
      w_clamped = '0;
    end else if (w_sum[DW]) begin
      w_clamped = '1;
    end else begin
      w_clamped = w_sum[DW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_last_up <= 1'b1;
      r_addr_q  <= '0;
      r_delta_q <= '0;
      r_wdata_q <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_win) begin
            r_state   <= RD_DATA;
            r_last_up <= 1'b0;
          end else if (w_up_win) begin
            r_state   <= UP_CALC;
            r_last_up <= 1'b1;
            r_addr_q  <= i_up_addr;
            r_delta_q <= i_up_delta;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_DATA: r_state <= IDLE;
        UP_CALC: begin
          r_wdata_q <= w_clamped;
          r_state   <= UP_WR;
        end
        UP_WR:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Grants must appear in the request cycle so the address reaches memory a cycle before data.
  always_comb begin
    o_rd_gnt    = 1'b0;
    o_rd_valid  = 1'b0;
    o_rd_data   = '0;
    o_up_gnt    = 1'b0;
    o_up_done   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_rd_win) begin
            o_rd_gnt   = 1'b1;
            o_mem_addr = i_rd_addr;
          end else if (w_up_win) begin
            o_up_gnt   = 1'b1;
            o_mem_addr = i_up_addr;
          end else begin
            o_mem_we = 1'b0;
          end
        end
        RD_DATA: begin
          o_rd_valid = 1'b1;
          o_rd_data  = i_mem_rdata;
        end
        UP_WR: begin
          o_mem_we    = 1'b1;
          o_mem_addr  = r_addr_q;
          o_mem_wdata = r_wdata_q;
          o_up_done   = 1'b1;
        end
        default: o_mem_we = 1'b0;
      endcase
    end else begin
      o_mem_we = 1'b0;
    end
  end

endmodule

// File: doc/weight_mem_arbiter.md
WEIGHT_MEM_ARBITER -- requirements
Module: weight_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, is the weight memory address width.
REQ-002 Parameter DW, default 8, is the weight and delta data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 learn_en  input  1  1 = update requests may be granted.
REQ-006 rd_req  input  1  inference read request; held until rd_gnt.
REQ-007 rd_addr  input  ADDR_W  read address, sampled in the rd_gnt cycle.
REQ-008 rd_gnt  output  1  one-cycle read grant.
REQ-009 rd_valid  output  1  one-cycle strobe; rd_data valid.
REQ-010 rd_data  output  DW  read weight.
REQ-011 up_req  input  1  reward update request; held until up_gnt.
REQ-012 up_addr  input  ADDR_W  update address, sampled in the up_gnt cycle.
REQ-013 up_delta  input  DW  signed two's-complement reward delta, sampled in the up_gnt cycle.
REQ-014 up_gnt  output  1  one-cycle update grant.
REQ-015 up_done  output  1  one-cycle strobe in the write-back cycle.
REQ-016 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DW  memory write enable, address and write data.
REQ-017 mem_rdata  input  DW  memory read data, valid one cycle after mem_addr is presented.

Function
REQ-018 The FSM SHALL have states IDLE, RD_DATA, UP_CALC and UP_WR.
REQ-019 In IDLE, eligible requests are rd_req and (up_req AND learn_en); with none eligible, the FSM SHALL stay in IDLE with mem_we=0.
REQ-020 With both eligible, the grant SHALL go to the requester other than last_winner (round-robin); last_winner updates on every grant.
REQ-021 Read grant: rd_gnt=1 and mem_addr=rd_addr in the same cycle; next state RD_DATA.
REQ-022 RD_DATA: rd_valid=1, rd_data=mem_rdata, mem_we=0; next state IDLE; read latency is 1 cycle from rd_gnt to rd_valid.
REQ-023 Update grant: up_gnt=1, mem_addr=up_addr, addr_q<=up_addr, delta_q<=up_delta; next state UP_CALC.
REQ-024 UP_CALC: sum = unsigned mem_rdata + signed delta_q, computed at DW+2 bits and clamped to [0, 2^DW-1]; the result is registered into wdata_q; next state UP_WR.
REQ-025 UP_WR: mem_we=1, mem_addr=addr_q, mem_wdata=wdata_q, up_done=1; next state IDLE.
REQ-026 An update SHALL occupy 3 cycles (grant, calc, write); no grant of either kind SHALL be issued outside IDLE.
REQ-027 mem_we SHALL be 1 only in UP_WR, so reads and writes never collide.
REQ-028 Deasserting learn_en after up_gnt SHALL NOT abort the update in flight.
REQ-029 rd_data SHALL be 0 when rd_valid=0.
REQ-030 Outside the grant and UP_WR cycles, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-031 When rst_n=0 at a clock edge, state<=IDLE and last_winner<=update, so a read wins the first tie.
REQ-032 Reset SHALL clear addr_q, delta_q and wdata_q to 0.
REQ-033 While rst_n=0, all outputs SHALL be 0.
REQ-034 Reset mid-operation SHALL abandon the operation: no mem_we and no up_done or rd_valid for it.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Read: mem[3]=0x2A, rd_req with rd_addr=3 -> rd_gnt in cycle 0; rd_valid=1 with rd_data=0x2A in cycle 1.
- Saturating update: mem[5]=0xF0, delta=+0x20 -> write 0xFF in UP_WR; mem[6]=0x10, delta=0x80 (-128) -> write 0x00; mem[7]=0x40, delta=0xFE -> write 0x3E.
- Contention: rd_req and up_req held from reset with learn_en=1 -> grants in order read, update, read, update; an update always takes 3 cycles, a read 2.
- Gating: learn_en=0 with up_req high for 20 cycles -> no up_gnt, reads still granted; learn_en=1 -> up_gnt on the next IDLE cycle.
- Reset: rst_n=0 during UP_CALC -> no mem_we and no up_done, FSM in IDLE, outputs 0.
- Coherence: update mem[2] 0x10 by +0x05, then read addr 2 -> rd_data=0x15.
